// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the ram_arbiter slice.
//   DW/AW/ADDR_W/STARVE_MAX : default widths and starvation limit
//   src_t                   : which requester a read response belongs to
//   rsp_tag_t               : tag carried alongside each response slot
//   addr_oor()              : out-of-range address test
package ram_arb_pkg;

  localparam int DW         = 20;
  localparam int AW         = 8;
  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_FETCH = 2'd1,
    SRC_HOST  = 2'd2
  } src_t;

  // err zeroes the read data of the tagged requester. wr_err flags a dropped
  // out-of-range host write; it needs its own bit because the same slot may
  // also carry a fetch read accepted in that cycle.
  typedef struct packed {
    src_t src;
    logic err;
    logic wr_err;
  } rsp_tag_t;

  localparam rsp_tag_t TAG_IDLE = '{src: SRC_NONE, err: 1'b0, wr_err: 1'b0};

  // Any address bit at or above aw set means the RAM does not implement it.
  function automatic logic addr_oor(input logic [ADDR_W-1:0] addr, input int aw);
    return ((addr >> aw) != 16'd0);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester and RAM-side signals of the ram_arbiter.
//   fetch_*  : fetch read request/grant and response
//   host_*   : host loader/debug request/grant and response
//   ce_ram/pc_final, we_ram/a/pc_modify, ram_dout : RAM port
// Modports: slave = the arbiter, master = the environment around it.
interface ram_arbiter_if #(
  parameter int DW = ram_arb_pkg::DW
);
  import ram_arb_pkg::*;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DW-1:0]     fetch_data;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DW-1:0]     host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DW-1:0]     host_rdata;
  logic              host_err;

  logic              ce_ram;
  logic              we_ram;
  logic [ADDR_W-1:0] pc_final;
  logic [ADDR_W-1:0] a;
  logic [20:0]       pc_modify;
  logic [DW-1:0]     ram_dout;

  modport slave (
    input  fetch_req, fetch_addr, host_req, host_we, host_addr, host_wdata, ram_dout,
    output fetch_gnt, fetch_valid, fetch_data,
    output host_gnt, host_rvalid, host_rdata, host_err,
    output ce_ram, we_ram, pc_final, a, pc_modify
  );

  modport master (
    output fetch_req, fetch_addr, host_req, host_we, host_addr, host_wdata, ram_dout,
    input  fetch_gnt, fetch_valid, fetch_data,
    input  host_gnt, host_rvalid, host_rdata, host_err,
    input  ce_ram, we_ram, pc_final, a, pc_modify
  );

endinterface

// File: rtl/ram_arb_rsp_pipe.sv
// ram_arb_rsp_pipe: two-stage response tag pipeline.
//   i_tag       : tag for the command issued this cycle
//   i_ram_dout  : RAM read data, valid in the cycle the tag reaches stage 2
//   o_fetch_*   : fetch response (valid pulse + data, data 0 when idle)
//   o_host_*    : host response; host_err also flags dropped writes
// RAM_ARB_READBACK_EN: when undefined, host read responses are tied to 0.
module ram_arb_rsp_pipe
  import ram_arb_pkg::*;
#(
  parameter int DW = ram_arb_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  rsp_tag_t      i_tag,
  input  logic [DW-1:0] i_ram_dout,
  output logic          o_fetch_valid,
  output logic [DW-1:0] o_fetch_data,
  output logic          o_host_rvalid,
  output logic [DW-1:0] o_host_rdata,
  output logic          o_host_err
);

  rsp_tag_t r_s1;
  rsp_tag_t r_s2;

  // Tag shift register; reset flushes anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= TAG_IDLE;
      r_s2 <= TAG_IDLE;
    end else begin
      r_s1 <= i_tag;
      r_s2 <= r_s1;
    end
  end

  assign o_fetch_valid = (r_s2.src == SRC_FETCH);
  assign o_fetch_data  = (o_fetch_valid && !r_s2.err) ? i_ram_dout : '0;

`ifdef RAM_ARB_READBACK_EN
  assign o_host_rvalid = (r_s2.src == SRC_HOST);
  assign o_host_rdata  = (o_host_rvalid && !r_s2.err) ? i_ram_dout : '0;
  assign o_host_err    = (o_host_rvalid && r_s2.err) || r_s2.wr_err;
`else
  assign o_host_rvalid = 1'b0;
  assign o_host_rdata  = '0;
  assign o_host_err    = r_s2.wr_err;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the 256x20 program RAM between instruction fetch and
// the host loader/debug port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ram_arbiter_if.slave (requester handshakes, responses, RAM port)
// Grants are combinational; all RAM commands are registered and read data
// returns two cycles after acceptance, routed by a tag pipeline.
// RAM_ARB_READBACK_EN: enables host reads and the host starvation counter.
// Undefined, every host request is a write and host_we is ignored.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW         = ram_arb_pkg::AW,
  parameter int DW         = ram_arb_pkg::DW,
  parameter int STARVE_MAX = ram_arb_pkg::STARVE_MAX
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  logic     w_f_oor;
  logic     w_h_oor;
  logic     w_host_wr;
  logic     w_host_rd;
  logic     w_host_wins;
  logic     w_hazard;
  logic     w_fetch_gnt;
  logic     w_host_gnt;
  logic     w_host_rd_acc;
  logic     w_issue_wr;
  logic     w_issue_rd;
  rsp_tag_t w_tag_in;

  logic              r_ce;
  logic              r_we;
  logic [ADDR_W-1:0] r_pc_final;
  logic [ADDR_W-1:0] r_a;
  logic [20:0]       r_pc_modify;

  assign w_f_oor = addr_oor(bus.fetch_addr, AW);
  assign w_h_oor = addr_oor(bus.host_addr, AW);

`ifdef RAM_ARB_READBACK_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] r_starve;

  assign w_host_wr   = bus.host_req & bus.host_we;
  assign w_host_rd   = bus.host_req & ~bus.host_we;
  assign w_host_wins = (r_starve == SCW'(STARVE_MAX));

  // Starvation counter: counts consecutive denied host reads, clears otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!bus.host_req || w_host_wr || w_host_rd_acc) begin
      r_starve <= '0;
    end else begin
      r_starve <= r_starve + SCW'(1);
    end
  end
`else
  logic w_unused_host_we;

  assign w_unused_host_we = bus.host_we;
  assign w_host_wr        = bus.host_req;
  assign w_host_rd        = 1'b0;
  assign w_host_wins      = 1'b0;
`endif

  // A same-cycle write and fetch to one real RAM word would race inside the
  // RAM, so the fetch is held off and retries after the write lands.
  assign w_hazard = w_host_wr & bus.fetch_req & ~w_f_oor & ~w_h_oor &
                    (bus.fetch_addr == bus.host_addr);

  // Read port: fetch wins unless the host has been starved long enough.
  assign w_fetch_gnt   = bus.fetch_req & ~w_hazard & ~(w_host_rd & w_host_wins);
  assign w_host_gnt    = bus.host_req & (w_host_wr | ~bus.fetch_req | w_host_wins);
  assign w_host_rd_acc = w_host_rd & w_host_gnt;

  assign bus.fetch_gnt = w_fetch_gnt;
  assign bus.host_gnt  = w_host_gnt;

  // Out-of-range accesses are accepted but never reach the RAM.
  assign w_issue_wr = w_host_wr & ~w_h_oor;
  assign w_issue_rd = (w_fetch_gnt & ~w_f_oor) | (w_host_rd_acc & ~w_h_oor);

  // RAM command registers; enables pulse one cycle, addresses hold between uses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce        <= 1'b0;
      r_we        <= 1'b0;
      r_pc_final  <= '0;
      r_a         <= '0;
      r_pc_modify <= '0;
    end else begin
      r_ce <= w_issue_rd;
      r_we <= w_issue_wr;
      if (w_host_rd_acc) begin
        r_pc_final <= bus.host_addr;
      end else if (w_fetch_gnt) begin
        r_pc_final <= bus.fetch_addr;
      end else begin
        r_pc_final <= r_pc_final;
      end
      if (w_issue_wr) begin
        r_a         <= bus.host_addr;
        r_pc_modify <= 21'(bus.host_wdata);
      end else begin
        r_a         <= r_a;
        r_pc_modify <= r_pc_modify;
      end
    end
  end

  assign bus.ce_ram    = r_ce;
  assign bus.we_ram    = r_we;
  assign bus.pc_final  = r_pc_final;
  assign bus.a         = r_a;
  assign bus.pc_modify = r_pc_modify;

  // Tag for this cycle's response slot; fetch and host reads are exclusive.
  always_comb begin
    w_tag_in = TAG_IDLE;
    if (w_fetch_gnt) begin
      w_tag_in.src = SRC_FETCH;
      w_tag_in.err = w_f_oor;
    end else if (w_host_rd_acc) begin
      w_tag_in.src = SRC_HOST;
      w_tag_in.err = w_h_oor;
    end else begin
      w_tag_in.src = SRC_NONE;
      w_tag_in.err = 1'b0;
    end
    w_tag_in.wr_err = w_host_wr & w_h_oor;
  end

  ram_arb_rsp_pipe #(
    .DW(DW)
  ) u_rsp_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tag        (w_tag_in),
    .i_ram_dout   (bus.ram_dout),
    .o_fetch_valid(bus.fetch_valid),
    .o_fetch_data (bus.fetch_data),
    .o_host_rvalid(bus.host_rvalid),
    .o_host_rdata (bus.host_rdata),
    .o_host_err   (bus.host_err)
  );

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sits in front of `my_ram`, the 256×20 program memory, and shares it between two requesters: instruction fetch and the host loader/debug port. It serializes read-port use, runs host writes in parallel with fetch when safe, blocks same-address read-after-write races, and returns tagged read data to the correct requester. All RAM-side command signals are registered, so the block also isolates requester timing from the RAM.

## Interface
- `AW`, 8: implemented RAM address bits; addresses with any bit set in [15:AW] are out of range.
- `DW`, 20: RAM data width.
- `STARVE_MAX`, 4: consecutive denied host-read cycles before the host is forced a grant.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `fetch_req` in 1, `fetch_addr` in 16: fetch read request and address.
- `fetch_gnt` out 1: combinational; the request is accepted in any cycle with `fetch_req && fetch_gnt`.
- `fetch_valid` out 1, `fetch_data` out DW: fetch read response.
- `host_req` in 1, `host_we` in 1, `host_addr` in 16, `host_wdata` in DW: host request; `host_we`=1 is a write.
- `host_gnt` out 1: combinational accept.
- `host_rvalid` out 1, `host_rdata` out DW, `host_err` out 1: host read response; `host_err` marks an out-of-range access.
- `ce_ram`, `we_ram` out 1; `pc_final`, `a` out 16; `pc_modify` out 21; `ram_dout` in DW: RAM-side port. `pc_modify[20]` is always 0.

## Operation
- Read port, driven by `ce_ram`/`pc_final`, is shared by fetch reads and host reads. Write port, driven by `we_ram`/`a`/`pc_modify`, is used only by host writes.
- Host write: always granted. In the same cycle a fetch read to a different address is also granted.
- Hazard: a fetch read to the same in-range address as a host write in the same cycle gets `fetch_gnt`=0 that cycle. The write goes first and the fetch retries.
- Read-port contention (host read with fetch read): fetch wins by default. A starvation counter increments on each denied host-read cycle. When it reaches `STARVE_MAX`, the host wins that cycle and the counter clears. The counter also clears on any host-read grant and whenever `host_req` is low.
- Out-of-range access: granted, but no RAM command is issued. A write is dropped. A read returns 0 with valid. `host_err` pulses with the host response, or in response slot N+2 for a write. Out-of-range fetch reads are silently granted and return 0.
- Response pipeline: a 2-stage tag {src, err} travels with each accepted read. At stage 2, `ram_dout` (or 0 if err) is routed to the tagged requester's data output and that requester's valid is pulsed for one cycle.
- No back-pressure on responses. Requesters must sink them.
- Reset values: all RAM-side outputs 0; `fetch_valid`, `host_rvalid`, `host_err` 0; data outputs 0; starvation counter 0; tags flushed. Reset mid-operation drops in-flight responses; no valid follows deassertion.

## Timing
- Cycle N: request and grant handshake (combinational grant from current inputs and counter).
- Edge ending N: RAM command registers load. `ce_ram`/`we_ram` are high in N+1 only.
- Edge ending N+1: RAM captures the write and registers the read.
- Cycle N+2: `*_valid` and data are presented (data passes through from `ram_dout`). Read latency is 2 cycles, fully pipelined, one read issued per cycle.
- A host write accepted in N is visible to a fetch read accepted in N+1 or later.

## Configuration
- `RAM_ARB_READBACK_EN` defined: host reads are supported as above.
- Undefined: `host_we` is ignored and every host request is a write. Host never contends for the read port. Starvation counter is removed. `host_rvalid`/`host_rdata` are tied 0. `host_err` still pulses for out-of-range writes.

## Structure
- Package `ram_arb_pkg`: `DW`, `AW`, `ADDR_W`=16, `STARVE_MAX` defaults; enum `src_t` {SRC_NONE, SRC_FETCH, SRC_HOST}; struct `rsp_tag_t` {src, err}.
- Sub-module `ram_arb_rsp_pipe`: 2-stage tag shift register with async reset. It produces the per-requester valid, err and data mux.

## Test plan
- Host write addr 0x10 data 0x5A5A5 in cycle 0, fetch read 0x10 in cycle 1: `we_ram`=1 in cycle 1; `fetch_valid` in cycle 3 with 0x5A5A5.
- Same-cycle host write 0x20 and fetch read 0x20: `fetch_gnt`=0 that cycle. Retried fetch next cycle returns the new data.
- Same-cycle host write 0x20 and fetch read 0x21: both granted; `we_ram` and `ce_ram` both 1 in the next cycle.
- `RAM_ARB_READBACK_EN`, fetch_req held high, host read 0x30 held: `host_gnt`=1 exactly on the 5th request cycle. `host_rvalid` follows 2 cycles later with the RAM contents.
- Host write to 0x0100: no `we_ram`; `host_err` pulse 2 cycles later. Host read 0x0100: `host_rvalid`=1, `host_rdata`=0, `host_err`=1.
- `rst_n` asserted with 2 reads in flight: all outputs 0 immediately; no valid after release.
